// File: rtl/tcp_new_flow_setup.sv
// Slow-path new-flow installer: allocates an ID, initialises state, then writes the CAM.
// Optional stat counters are enabled with `define TCP_FLOW_SETUP_STATS_EN.
module tcp_new_flow_setup #(
    parameter int          FLOWID_W      = 3,
    parameter int          PTR_W         = 16,
    parameter int          RECYCLE_DEPTH = 4,
    parameter logic [31:0] TX_ISN        = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  slow_path_val,
    output logic                  slow_path_rdy,
    input  logic [95:0]           slow_path_tuple,
    input  logic [31:0]           slow_path_seq,

    output logic                  slow_path_done_val,
    input  logic                  slow_path_done_rdy,
    output logic [FLOWID_W-1:0]   slow_path_done_flowid,
    output logic                  slow_path_done_fail,

    output logic                  rx_state_wr_val,
    input  logic                  rx_state_wr_rdy,
    output logic [31:0]           rx_state_wr_data,

    output logic                  tx_state_wr_val,
    input  logic                  tx_state_wr_rdy,
    output logic [63:0]           tx_state_wr_data,

    output logic                  rx_ptrs_wr_val,
    input  logic                  rx_ptrs_wr_rdy,
    output logic [2*PTR_W-1:0]    rx_ptrs_wr_data,

    output logic                  tx_ptrs_wr_val,
    input  logic                  tx_ptrs_wr_rdy,
    output logic [2*PTR_W-1:0]    tx_ptrs_wr_data,

    output logic [FLOWID_W-1:0]   state_wr_flowid,

    output logic                  cam_wr_val,
    input  logic                  cam_wr_rdy,
    output logic [95:0]           cam_wr_tuple,
    output logic [FLOWID_W-1:0]   cam_wr_flowid,

    input  logic                  flow_free_val,
    output logic                  flow_free_rdy,
    input  logic [FLOWID_W-1:0]   flow_free_flowid
`ifdef TCP_FLOW_SETUP_STATS_EN
    ,
    output logic [31:0]           stat_setups,
    output logic [31:0]           stat_fails
`endif
);

    localparam logic [FLOWID_W:0] MAX_FLOWS = {1'b1, {FLOWID_W{1'b0}}};
    localparam int AW = $clog2(RECYCLE_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALLOC,
        S_INIT,
        S_CAM,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [95:0]           tuple_q, tuple_d;
    logic [31:0]           seq_q, seq_d;
    logic [FLOWID_W-1:0]   flowid_q, flowid_d;
    logic                  fail_q, fail_d;
    logic [3:0]            pend_q, pend_d;
    logic [FLOWID_W:0]     next_id_q, next_id_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [FLOWID_W-1:0]   fifo_q [RECYCLE_DEPTH];

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic                  in_init;
    logic [3:0]            wr_hs;

    assign fifo_empty = (rd_ptr_q == wr_ptr_q);
    assign fifo_full  = (rd_ptr_q[AW] != wr_ptr_q[AW]) &&
                        (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
    assign push       = flow_free_val && !fifo_full;
    assign flow_free_rdy = !fifo_full;

    // Bit order of the pending mask: rx_state, tx_state, rx_ptrs, tx_ptrs.
    assign in_init         = (state_q == S_INIT);
    assign rx_state_wr_val = in_init && pend_q[0];
    assign tx_state_wr_val = in_init && pend_q[1];
    assign rx_ptrs_wr_val  = in_init && pend_q[2];
    assign tx_ptrs_wr_val  = in_init && pend_q[3];

    assign wr_hs = {tx_ptrs_wr_val && tx_ptrs_wr_rdy,
                    rx_ptrs_wr_val && rx_ptrs_wr_rdy,
                    tx_state_wr_val && tx_state_wr_rdy,
                    rx_state_wr_val && rx_state_wr_rdy};

    assign rx_state_wr_data = seq_q + 32'd1;
    assign tx_state_wr_data = {TX_ISN, TX_ISN};
    assign rx_ptrs_wr_data  = '0;
    assign tx_ptrs_wr_data  = '0;
    assign state_wr_flowid  = flowid_q;

    assign cam_wr_val    = (state_q == S_CAM);
    assign cam_wr_tuple  = tuple_q;
    assign cam_wr_flowid = flowid_q;

    assign slow_path_rdy         = (state_q == S_IDLE);
    assign slow_path_done_val    = (state_q == S_DONE);
    assign slow_path_done_flowid = flowid_q;
    assign slow_path_done_fail   = fail_q;

    always_comb begin
        state_d   = state_q;
        tuple_d   = tuple_q;
        seq_d     = seq_q;
        flowid_d  = flowid_q;
        fail_d    = fail_q;
        pend_d    = pend_q;
        next_id_d = next_id_q;
        pop       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (slow_path_val) begin
                    tuple_d = slow_path_tuple;
                    seq_d   = slow_path_seq;
                    state_d = S_ALLOC;
                end
            end
            S_ALLOC: begin
                // Recycled IDs take priority; the counter saturates, never wraps.
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    flowid_d = fifo_q[rd_ptr_q[AW-1:0]];
                    pend_d   = 4'b1111;
                    state_d  = S_INIT;
                end else if (next_id_q < MAX_FLOWS) begin
                    flowid_d  = next_id_q[FLOWID_W-1:0];
                    next_id_d = next_id_q + (FLOWID_W+1)'(1);
                    pend_d    = 4'b1111;
                    state_d   = S_INIT;
                end else begin
                    fail_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_INIT: begin
                pend_d = pend_q & ~wr_hs;
                if (pend_q == 4'b0000) begin
                    state_d = S_CAM;
                end
            end
            S_CAM: begin
                if (cam_wr_rdy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (slow_path_done_rdy) begin
                    fail_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tuple_q   <= '0;
            seq_q     <= '0;
            flowid_q  <= '0;
            fail_q    <= 1'b0;
            pend_q    <= '0;
            next_id_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            tuple_q   <= tuple_d;
            seq_q     <= seq_d;
            flowid_q  <= flowid_d;
            fail_q    <= fail_d;
            pend_q    <= pend_d;
            next_id_q <= next_id_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= flow_free_flowid;
        end
    end

`ifdef TCP_FLOW_SETUP_STATS_EN
    logic [31:0] stat_setups_q, stat_setups_d;
    logic [31:0] stat_fails_q, stat_fails_d;
    logic        done_hs;

    assign done_hs     = slow_path_done_val && slow_path_done_rdy;
    assign stat_setups = stat_setups_q;
    assign stat_fails  = stat_fails_q;

    always_comb begin
        stat_setups_d = stat_setups_q;
        stat_fails_d  = stat_fails_q;
        if (done_hs && !fail_q) begin
            stat_setups_d = stat_setups_q + 32'd1;
        end
        if (done_hs && fail_q) begin
            stat_fails_d = stat_fails_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_setups_q <= '0;
            stat_fails_q  <= '0;
        end else begin
            stat_setups_q <= stat_setups_d;
            stat_fails_q  <= stat_fails_d;
        end
    end
`endif

endmodule

// File: tb/tb_tcp_new_flow_setup.sv
// Randomized self-checking bench for tcp_new_flow_setup against an ID-allocation model.
// Stat counters are checked when TCP_FLOW_SETUP_STATS_EN is defined.
module tb_tcp_new_flow_setup;

    localparam int          FW    = 3;
    localparam int          PW    = 16;
    localparam int          DEPTH = 4;
    localparam int          NFLOW = 8;
    localparam logic [31:0] ISN   = 32'h1357_9BDF;

    logic            clk = 1'b0;
    logic            rst;
    logic            slow_path_val;
    logic            slow_path_rdy;
    logic [95:0]     slow_path_tuple;
    logic [31:0]     slow_path_seq;
    logic            slow_path_done_val;
    logic            slow_path_done_rdy;
    logic [FW-1:0]   slow_path_done_flowid;
    logic            slow_path_done_fail;
    logic            rx_state_wr_val, rx_state_wr_rdy;
    logic [31:0]     rx_state_wr_data;
    logic            tx_state_wr_val, tx_state_wr_rdy;
    logic [63:0]     tx_state_wr_data;
    logic            rx_ptrs_wr_val, rx_ptrs_wr_rdy;
    logic [2*PW-1:0] rx_ptrs_wr_data;
    logic            tx_ptrs_wr_val, tx_ptrs_wr_rdy;
    logic [2*PW-1:0] tx_ptrs_wr_data;
    logic [FW-1:0]   state_wr_flowid;
    logic            cam_wr_val, cam_wr_rdy;
    logic [95:0]     cam_wr_tuple;
    logic [FW-1:0]   cam_wr_flowid;
    logic            flow_free_val, flow_free_rdy;
    logic [FW-1:0]   flow_free_flowid;
`ifdef TCP_FLOW_SETUP_STATS_EN
    logic [31:0]     stat_setups, stat_fails;
`endif

    always #5 clk = ~clk;

    tcp_new_flow_setup #(
        .FLOWID_W(FW), .PTR_W(PW), .RECYCLE_DEPTH(DEPTH), .TX_ISN(ISN)
    ) dut (
        .clk(clk), .rst(rst),
        .slow_path_val(slow_path_val), .slow_path_rdy(slow_path_rdy),
        .slow_path_tuple(slow_path_tuple), .slow_path_seq(slow_path_seq),
        .slow_path_done_val(slow_path_done_val),
        .slow_path_done_rdy(slow_path_done_rdy),
        .slow_path_done_flowid(slow_path_done_flowid),
        .slow_path_done_fail(slow_path_done_fail),
        .rx_state_wr_val(rx_state_wr_val), .rx_state_wr_rdy(rx_state_wr_rdy),
        .rx_state_wr_data(rx_state_wr_data),
        .tx_state_wr_val(tx_state_wr_val), .tx_state_wr_rdy(tx_state_wr_rdy),
        .tx_state_wr_data(tx_state_wr_data),
        .rx_ptrs_wr_val(rx_ptrs_wr_val), .rx_ptrs_wr_rdy(rx_ptrs_wr_rdy),
        .rx_ptrs_wr_data(rx_ptrs_wr_data),
        .tx_ptrs_wr_val(tx_ptrs_wr_val), .tx_ptrs_wr_rdy(tx_ptrs_wr_rdy),
        .tx_ptrs_wr_data(tx_ptrs_wr_data),
        .state_wr_flowid(state_wr_flowid),
        .cam_wr_val(cam_wr_val), .cam_wr_rdy(cam_wr_rdy),
        .cam_wr_tuple(cam_wr_tuple), .cam_wr_flowid(cam_wr_flowid),
        .flow_free_val(flow_free_val), .flow_free_rdy(flow_free_rdy),
        .flow_free_flowid(flow_free_flowid)
`ifdef TCP_FLOW_SETUP_STATS_EN
        ,
        .stat_setups(stat_setups), .stat_fails(stat_fails)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: free-ID queue, saturating counter, set of live IDs.
    int next_id;
    int rq[$];
    bit alloc[NFLOW];
    int exp_setups;
    int exp_fails;

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        next_id = 0;
        rq.delete();
        for (int i = 0; i < NFLOW; i++) alloc[i] = 1'b0;
        exp_setups = 0;
        exp_fails  = 0;
    endtask

    task automatic model_alloc(output int id, output bit fail);
        id   = 0;
        fail = 1'b0;
        if (rq.size() != 0) begin
            id = rq.pop_front();
        end else if (next_id < NFLOW) begin
            id = next_id;
            next_id++;
        end else begin
            fail = 1'b1;
        end
    endtask

    task automatic set_rdys(input bit v);
        rx_state_wr_rdy    = v;
        tx_state_wr_rdy    = v;
        rx_ptrs_wr_rdy     = v;
        tx_ptrs_wr_rdy     = v;
        cam_wr_rdy         = v;
        slow_path_done_rdy = v;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_vals"},
                 {rx_state_wr_val, tx_state_wr_val, rx_ptrs_wr_val,
                  tx_ptrs_wr_val, cam_wr_val, slow_path_done_val}, 6'b0);
        check_eq({tag, "_req_rdy"}, slow_path_rdy, 1'b1);
    endtask

    // mode 0: all rdys high; 1: random rdys; 2: tx_ptrs held off 5 INIT cycles.
    task automatic do_setup(input logic [95:0] tup, input logic [31:0] sq,
                            input int mode);
        int eid;
        bit efail;
        int hs[5];
        int n;
        bit done;
        logic [31:0] rcv;
        model_alloc(eid, efail);
        rcv = sq + 32'd1;
        for (int i = 0; i < 5; i++) hs[i] = 0;
        n = 0;
        while (!slow_path_rdy && n < 50) begin
            step();
            n++;
        end
        check_eq("req_rdy", slow_path_rdy, 1'b1);
        slow_path_val   = 1'b1;
        slow_path_tuple = tup;
        slow_path_seq   = sq;
        step();
        slow_path_val   = 1'b0;
        slow_path_tuple = {$urandom, $urandom, $urandom};
        slow_path_seq   = $urandom;
        done = 1'b0;
        n    = 0;
        while (!done && n < 300) begin
            if (rx_state_wr_val) begin
                check_eq("rx_state_once", hs[0], 0);
                check_eq("rcv_nxt", rx_state_wr_data, rcv);
                check_eq("rx_state_id", state_wr_flowid, eid);
            end
            if (tx_state_wr_val) begin
                check_eq("tx_state_once", hs[1], 0);
                check_eq("snd", tx_state_wr_data, {ISN, ISN});
                check_eq("tx_state_id", state_wr_flowid, eid);
            end
            if (rx_ptrs_wr_val) begin
                check_eq("rx_ptrs_once", hs[2], 0);
                check_eq("rx_ptrs", rx_ptrs_wr_data, 0);
                check_eq("rx_ptrs_id", state_wr_flowid, eid);
            end
            if (tx_ptrs_wr_val) begin
                check_eq("tx_ptrs_once", hs[3], 0);
                check_eq("tx_ptrs", tx_ptrs_wr_data, 0);
                check_eq("tx_ptrs_id", state_wr_flowid, eid);
            end
            if (mode == 2 && n >= 1 && n <= 6)
                check_eq("txp_hold", tx_ptrs_wr_val, 1'b1);
            if (efail)
                check_eq("write_on_fail",
                         {rx_state_wr_val, tx_state_wr_val, rx_ptrs_wr_val,
                          tx_ptrs_wr_val, cam_wr_val}, 5'b0);
            if (cam_wr_val) begin
                check_eq("cam_order", hs[0] + hs[1] + hs[2] + hs[3], 4);
                check_eq("cam_once", hs[4], 0);
                check_eq("cam_tuple", cam_wr_tuple, tup);
                check_eq("cam_id", cam_wr_flowid, eid);
            end
            if (slow_path_done_val) begin
                check_eq("done_fail", slow_path_done_fail, efail);
                if (!efail) begin
                    check_eq("done_id", slow_path_done_flowid, eid);
                    check_eq("done_writes", hs[0] + hs[1] + hs[2] + hs[3] + hs[4], 5);
                    if (mode == 0) check_eq("latency", n, 4);
                end else begin
                    check_eq("fail_writes", hs[0] + hs[1] + hs[2] + hs[3] + hs[4], 0);
                end
            end
            if (mode == 1) begin
                rx_state_wr_rdy    = ($urandom % 4) != 0;
                tx_state_wr_rdy    = ($urandom % 4) != 0;
                rx_ptrs_wr_rdy     = ($urandom % 4) != 0;
                tx_ptrs_wr_rdy     = ($urandom % 4) != 0;
                cam_wr_rdy         = ($urandom % 3) != 0;
                slow_path_done_rdy = ($urandom % 3) != 0;
            end else begin
                set_rdys(1'b1);
                if (mode == 2) tx_ptrs_wr_rdy = (n >= 6);
            end
            if (rx_state_wr_val && rx_state_wr_rdy) hs[0]++;
            if (tx_state_wr_val && tx_state_wr_rdy) hs[1]++;
            if (rx_ptrs_wr_val && rx_ptrs_wr_rdy)   hs[2]++;
            if (tx_ptrs_wr_val && tx_ptrs_wr_rdy)   hs[3]++;
            if (cam_wr_val && cam_wr_rdy)           hs[4]++;
            if (slow_path_done_val && slow_path_done_rdy) done = 1'b1;
            step();
            n++;
        end
        if (!done) check_eq("timeout", 1'b1, 1'b0);
        set_rdys(1'b0);
        if (efail) exp_fails++;
        else begin
            exp_setups++;
            alloc[eid] = 1'b1;
        end
    endtask

    task automatic do_free(input int id);
        int n;
        check_eq("free_rdy", flow_free_rdy, rq.size() < DEPTH);
        n = 0;
        while (!flow_free_rdy && n < 20) begin
            step();
            n++;
        end
        flow_free_val    = 1'b1;
        flow_free_flowid = id[FW-1:0];
        step();
        flow_free_val = 1'b0;
        rq.push_back(id);
        alloc[id] = 1'b0;
    endtask

    function automatic logic [95:0] rnd_tuple();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        int live[$];
        rst              = 1'b1;
        slow_path_val    = 1'b0;
        slow_path_tuple  = '0;
        slow_path_seq    = '0;
        flow_free_val    = 1'b0;
        flow_free_flowid = '0;
        set_rdys(1'b0);
        model_reset();
        repeat (3) step();
        check_quiet("reset");
        check_eq("reset_done_id", slow_path_done_flowid, 0);
        check_eq("reset_done_fail", slow_path_done_fail, 1'b0);
        check_eq("reset_free_rdy", flow_free_rdy, 1'b1);
        rst = 1'b0;
        step();

        do_setup(96'hC0A80001_C0A80002_1F90_0050, 32'h1000, 0);
        do_setup(rnd_tuple(), $urandom, 2);
        for (int i = 0; i < 6; i++) do_setup(rnd_tuple(), $urandom, 1);
        do_setup(rnd_tuple(), $urandom, 0);
        do_setup(rnd_tuple(), $urandom, 1);

        do_free(5);
        do_setup(rnd_tuple(), $urandom, 0);
        do_free(2);
        do_free(6);
        do_setup(rnd_tuple(), $urandom, 1);
        do_setup(rnd_tuple(), $urandom, 0);

        do_free(0);
        do_free(1);
        do_free(3);
        do_free(4);
        check_eq("fifo_full", flow_free_rdy, 1'b0);
        for (int i = 0; i < 5; i++) do_setup(rnd_tuple(), $urandom, 1);

        do_free(7);
        do_setup(rnd_tuple(), 32'hFFFF_FFFF, 0);

`ifdef TCP_FLOW_SETUP_STATS_EN
        check_eq("stat_setups", stat_setups, exp_setups);
        check_eq("stat_fails", stat_fails, exp_fails);
`endif

        // Abort a setup mid-INIT: the allocation must be forgotten.
        do_free(3);
        slow_path_val   = 1'b1;
        slow_path_tuple = rnd_tuple();
        slow_path_seq   = $urandom;
        step();
        slow_path_val = 1'b0;
        step();
        check_eq("init_reached", rx_state_wr_val, 1'b1);
        rst = 1'b1;
        step();
        check_quiet("mid_rst");
        rst = 1'b0;
        model_reset();
        step();
        do_setup(rnd_tuple(), $urandom, 0);

        for (int it = 0; it < 40; it++) begin
            live.delete();
            for (int i = 0; i < NFLOW; i++) if (alloc[i]) live.push_back(i);
            if (($urandom % 3) == 0 && live.size() != 0 && rq.size() < DEPTH)
                do_free(live[$urandom_range(0, live.size() - 1)]);
            else
                do_setup(rnd_tuple(), $urandom, (($urandom % 4) == 0) ? 0 : 1);
        end

`ifdef TCP_FLOW_SETUP_STATS_EN
        check_eq("stat_setups_end", stat_setups, exp_setups);
        check_eq("stat_fails_end", stat_fails, exp_fails);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
